audio_system_key_pio: RTL



---
 rtl/audio_system_pio_pkg.sv | 23 ++
 rtl/audio_system_pio_sync_edge.sv | 78 +++++++
 rtl/audio_system_key_pio.sv | 113 +++++++++++
 3 files changed

// File: rtl/audio_system_pio_pkg.sv
// rtl/audio_system_pio_pkg.sv - shared constants and types for the audio_system input PIO
// AUDIO_SYSTEM_KEY_PIO_DEBOUNCE_EN selects the debounced build.
package audio_system_pio_pkg;

  localparam int unsigned RDATA_W = 32;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

`ifdef AUDIO_SYSTEM_KEY_PIO_DEBOUNCE_EN
  localparam bit DEBOUNCE_EN = 1'b1;
`else
  localparam bit DEBOUNCE_EN = 1'b0;
`endif

endpackage

// File: rtl/audio_system_pio_sync_edge.sv
// rtl/audio_system_pio_sync_edge.sv - per-bit synchroniser, optional debouncer and edge detector
// Debouncer present only when AUDIO_SYSTEM_KEY_PIO_DEBOUNCE_EN is defined.
module audio_system_pio_sync_edge #(
  parameter int SYNC_STAGES = 2
`ifdef AUDIO_SYSTEM_KEY_PIO_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 50000
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   level;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef AUDIO_SYSTEM_KEY_PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;

  // Any cycle where sync agrees with the debounced value restarts the count.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign level = deb_q;
`else
  assign level = sync;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign level_o = level;
  assign rise_o  = level & ~prev_q;
  assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/audio_system_key_pio.sv
// rtl/audio_system_key_pio.sv - Avalon-MM push-button input PIO with edge capture and masked irq
// Build option: AUDIO_SYSTEM_KEY_PIO_DEBOUNCE_EN adds a per-bit debouncer.
module audio_system_key_pio
  import audio_system_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam edge_type_e EDGE_SEL   = edge_type_e'(EDGE_TYPE[1:0]);
  localparam int         ARM_CYCLES = SYNC_STAGES + 1 + (DEBOUNCE_EN ? DEBOUNCE_CYCLES : 0);
  localparam int         ARM_W      = $clog2(ARM_CYCLES + 1);

  logic [WIDTH-1:0]   level_vec, rise_vec, fall_vec, edge_vec;
  logic [WIDTH-1:0]   clr_vec;
  logic [WIDTH-1:0]   cap_q, cap_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [RDATA_W-1:0] readdata_q, readdata_d;
  logic               irq_q, irq_d;
  logic [ARM_W-1:0]   arm_cnt_q;
  logic               armed_q;
  logic               wr_en;
  logic               unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    audio_system_pio_sync_edge #(
      .SYNC_STAGES    (SYNC_STAGES)
`ifdef AUDIO_SYSTEM_KEY_PIO_DEBOUNCE_EN
      , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
    ) u_sync_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .in_i    (in_port[i]),
      .level_o (level_vec[i]),
      .rise_o  (rise_vec[i]),
      .fall_o  (fall_vec[i])
    );
  end

  // Idle-high keys look like edges while the synchronisers fill after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else if (!armed_q) begin
      arm_cnt_q <= arm_cnt_q + 1'b1;
      armed_q   <= (arm_cnt_q == ARM_W'(ARM_CYCLES - 1));
    end
  end

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    edge_vec = '0;
    case (EDGE_SEL)
      EDGE_RISE: edge_vec = rise_vec;
      EDGE_FALL: edge_vec = fall_vec;
      default:   edge_vec = rise_vec | fall_vec;
    endcase
  end

  // Set beats clear so an edge arriving with a W1C write is never lost.
  always_comb begin
    clr_vec = '0;
    mask_d  = mask_q;
    if (wr_en && address == ADDR_EDGE_CAP) clr_vec = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_IRQ_MASK) mask_d  = writedata[WIDTH-1:0];
    cap_d = (cap_q & ~clr_vec) | (armed_q ? edge_vec : '0);
    irq_d = |(cap_q & mask_q);
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:     readdata_d[WIDTH-1:0] = level_vec;
      ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = cap_q;
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q      <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      cap_q      <= cap_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
